// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_t;

   localparam logic [31:0] ERR_DATA   = 32'hDEADBEEF;
   localparam int          WORD_BYTES = 4;
   localparam int          WAIT_W     = 4;

   // An access is illegal when it is not word aligned or its word index is
   // beyond the end of the array.
   function automatic logic addr_err(input logic [31:0] adr, input int unsigned depth);
      return (adr[$clog2(WORD_BYTES)-1:0] != '0) || ({2'b00, adr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, combinational read.
module mem_array #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wd,
   output logic [31:0]              rd
);

   logic [31:0] mem_q [DEPTH];

   // Write port.
   // NOTE: the storage array has no reset; its contents survive reset and
   // a reset term would stop it mapping onto RAM cells.
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wd;
   end

   assign rd = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: req/ready handshake with WAIT_CYCLES wait states in
// front of a word RAM, with misaligned/out-of-range error reporting.
// Build option: define MEM_STATS_EN to add saturating read/write counters
// (rd_count, wr_count) for non-errored responses.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        ready,
   output logic        err
`ifdef MEM_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);

   localparam int AW = $clog2(DEPTH);

   mem_state_t        state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       wd_q, wd_d;
   logic              we_q, we_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [31:0]       cur_adr;
   logic              cur_we;
   logic [31:0]       ram_rd;
   logic              ram_we;

   // In IDLE the live inputs describe the access being accepted (needed when
   // WAIT_CYCLES=0 enters RESP straight from IDLE); afterwards the latched copy.
   assign cur_adr = (state_q == IDLE) ? Adr : adr_q;
   assign cur_we  = (state_q == IDLE) ? MemWrite : we_q;

   mem_array #(.DEPTH(DEPTH)) u_array (
      .clk  (clk),
      .we   (ram_we),
      .addr (cur_adr[AW+1:2]),
      .wd   (wd_q),
      .rd   (ram_rd)
   );

   // Next-state, handshake outputs and read-data capture.
   // NOTE: every signal driven here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      wd_d    = wd_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      ready   = 1'b0;
      err     = 1'b0;
      ram_we  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               adr_d = Adr;
               wd_d  = WriteData;
               we_d  = MemWrite;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  cnt_d   = WAIT_W'(WAIT_CYCLES);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - WAIT_W'(1);
            if (cnt_q == WAIT_W'(1)) state_d = RESP;
         end
         RESP: begin
            ready   = 1'b1;
            err     = addr_err(adr_q, DEPTH);
            // The write commits on the edge leaving RESP, before any
            // following access can reach its own RESP.
            ram_we  = we_q && !err;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Read data is captured on the edge entering RESP and then held.
      if (state_d == RESP && state_q != RESP && !cur_we)
         rdata_d = addr_err(cur_adr, DEPTH) ? ERR_DATA : ram_rd;
   end

   // State and request registers; reset abandons any pending access.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         wd_q    <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         wd_q    <= wd_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   assign ReadData = rdata_q;

`ifdef MEM_STATS_EN
   logic [15:0] rd_cnt_q, wr_cnt_q;

   // Saturating counters of successful reads and writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (ready && !err) begin
         if (we_q && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (!we_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with WAIT_CYCLES=2 (u_dut2) and one
// with WAIT_CYCLES=0 (u_dut0); responses checked against a scoreboard queue.
module tb_mem_responder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        req2 = 1'b0, mw2 = 1'b0, rdy2, err2;
   logic [31:0] adr2 = '0, wd2 = '0, rd2;
   logic        req0 = 1'b0, mw0 = 1'b0, rdy0, err0;
   logic [31:0] adr0 = '0, wd0 = '0, rd0;
`ifdef MEM_STATS_EN
   logic [15:0] rdc2, wrc2, rdc0, wrc0;
`endif

   mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .reset(reset), .req(req2), .MemWrite(mw2), .Adr(adr2),
      .WriteData(wd2), .ReadData(rd2), .ready(rdy2), .err(err2)
`ifdef MEM_STATS_EN
      , .rd_count(rdc2), .wr_count(wrc2)
`endif
   );

   mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .req(req0), .MemWrite(mw0), .Adr(adr0),
      .WriteData(wd0), .ReadData(rd0), .ready(rdy0), .err(err0)
`ifdef MEM_STATS_EN
      , .rd_count(rdc0), .wr_count(wrc0)
`endif
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        q2[$], q0[$];
   exp_t        m2, m0;
   logic [31:0] model2[64], model0[64];
   logic [31:0] last2 = '0, last0 = '0;
   int          checks = 0, failures = 0;

   // Response monitors: pop one expectation per ready pulse.
   always @(negedge clk) begin
      if (rdy2 === 1'b1) begin
         checks++;
         if (q2.size() == 0) begin
            failures++; $display("FAIL dut2_unexpected_ready t=%0t", $time);
         end else begin
            m2 = q2.pop_front();
            if (rd2 !== m2.rdata) begin
               failures++; $display("FAIL dut2_rdata got=%h exp=%h t=%0t", rd2, m2.rdata, $time);
            end
            checks++;
            if (err2 !== m2.err) begin
               failures++; $display("FAIL dut2_err got=%b exp=%b t=%0t", err2, m2.err, $time);
            end
         end
      end else begin
         checks++;
         if (err2 !== 1'b0) begin
            failures++; $display("FAIL dut2_err_idle got=%b exp=0 t=%0t", err2, $time);
         end
      end
   end

   always @(negedge clk) begin
      if (rdy0 === 1'b1) begin
         checks++;
         if (q0.size() == 0) begin
            failures++; $display("FAIL dut0_unexpected_ready t=%0t", $time);
         end else begin
            m0 = q0.pop_front();
            if (rd0 !== m0.rdata) begin
               failures++; $display("FAIL dut0_rdata got=%h exp=%h t=%0t", rd0, m0.rdata, $time);
            end
            checks++;
            if (err0 !== m0.err) begin
               failures++; $display("FAIL dut0_err got=%b exp=%b t=%0t", err0, m0.err, $time);
            end
         end
      end else begin
         checks++;
         if (err0 !== 1'b0) begin
            failures++; $display("FAIL dut0_err_idle got=%b exp=0 t=%0t", err0, $time);
         end
      end
   end

   // Expected response for an access; updates the reference memory model.
   function automatic exp_t mk_exp(input bit sel0, input logic w, input logic [31:0] a,
                                   input logic [31:0] d);
      exp_t e;
      e.err = (a[1:0] != 2'b00) || (a >= 32'h100);
      if (w) begin
         e.rdata = sel0 ? last0 : last2;
         if (!e.err) begin
            if (sel0) model0[a[7:2]] = d;
            else      model2[a[7:2]] = d;
         end
      end else begin
         e.rdata = e.err ? 32'hDEADBEEF : (sel0 ? model0[a[7:2]] : model2[a[7:2]]);
         if (sel0) last0 = e.rdata;
         else      last2 = e.rdata;
      end
      return e;
   endfunction

   // One access; lat = negedges from the accepting edge until ready.
   task automatic access(input bit sel0, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lat);
      exp_t e;
      e = mk_exp(sel0, w, a, d);
      @(negedge clk);
      if (sel0) begin q0.push_back(e); req0 = 1'b1; mw0 = w; adr0 = a; wd0 = d; end
      else      begin q2.push_back(e); req2 = 1'b1; mw2 = w; adr2 = a; wd2 = d; end
      @(negedge clk);
      req0 = 1'b0; req2 = 1'b0;
      lat = 1;
      while ((sel0 ? rdy0 : rdy2) !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL reset_ready2 got=%b exp=0", rdy2); end
      checks++; if (rd2 !== 32'h0) begin failures++; $display("FAIL reset_rdata2 got=%h exp=0", rd2); end
      checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", rdy0); end
      checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rd0); end
`ifdef MEM_STATS_EN
      checks++; if (rdc2 !== 16'h0 || wrc2 !== 16'h0) begin
         failures++; $display("FAIL reset_stats got=%h/%h exp=0/0", rdc2, wrc2);
      end
`endif
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int lat;
      access(1'b0, 1'b1, 32'h8, 32'h12345678, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      access(1'b0, 1'b0, 32'h8, 32'h0, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      @(negedge clk);
      checks++; if (rd2 !== 32'h12345678) begin
         failures++; $display("FAIL rdata_hold got=%h exp=12345678", rd2);
      end
   endtask

   task automatic test_zero_wait();
      int lat;
      access(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, lat);
      checks++; if (lat !== 1) begin failures++; $display("FAIL w0_wr_latency got=%0d exp=1", lat); end
      access(1'b1, 1'b0, 32'h0, 32'h0, lat);
      checks++; if (lat !== 1) begin failures++; $display("FAIL w0_rd_latency got=%0d exp=1", lat); end
   endtask

   task automatic test_errors();
      int lat;
      access(1'b1, 1'b0, 32'h6, 32'h0, lat);          // misaligned read
      checks++; if (rd0 !== 32'hDEADBEEF) begin
         failures++; $display("FAIL misaligned_rd got=%h exp=deadbeef", rd0);
      end
      access(1'b1, 1'b1, 32'h2, 32'h1, lat);          // misaligned write
      access(1'b1, 1'b0, 32'h0, 32'h0, lat);
      access(1'b0, 1'b1, 32'h0, 32'h11111111, lat);
      access(1'b0, 1'b1, 32'h100, 32'h22222222, lat); // out of range, aliases word 0
      access(1'b0, 1'b0, 32'h0, 32'h0, lat);
      access(1'b0, 1'b0, 32'h8, 32'h0, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL err_rd_latency got=%0d exp=3", lat); end
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic [31:0] addrs[3];
      logic [12:0] mask;
      exp_t        e;
      access(1'b0, 1'b1, 32'h14, 32'h5555AAAA, lat);
      addrs[0] = 32'h14; addrs[1] = 32'h0; addrs[2] = 32'h8;
      mask = '0;
      e = mk_exp(1'b0, 1'b0, addrs[0], 32'h0);
      @(negedge clk);
      q2.push_back(e); req2 = 1'b1; mw2 = 1'b0; adr2 = addrs[0];
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (rdy2 === 1'b1) mask[k] = 1'b1;
         if (k % 4 == 0 && k < 12) begin
            e = mk_exp(1'b0, 1'b0, addrs[k/4], 32'h0);
            q2.push_back(e);
            adr2 = addrs[k/4];
         end else begin
            adr2 = $urandom;
         end
         if (k == 9) req2 = 1'b0;
      end
      checks++; if (mask !== 13'h0888) begin
         failures++; $display("FAIL b2b_ready_pattern got=%h exp=0888", mask);
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, lat);
      access(1'b0, 1'b0, 32'h10, 32'h0, lat);
      @(negedge clk);
      req2 = 1'b1; mw2 = 1'b1; adr2 = 32'h10; wd2 = 32'hFFFF0000;
      @(negedge clk);
      req2 = 1'b0;
      reset = 1'b0;
      #1;
      checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", rdy2); end
      checks++; if (rd2 !== 32'h0) begin failures++; $display("FAIL abort_rdata got=%h exp=0", rd2); end
      last2 = '0; last0 = '0;
      @(negedge clk);
      reset = 1'b1;
      access(1'b0, 1'b0, 32'h10, 32'h0, lat);
      checks++; if (rd2 !== 32'hCAFEF00D) begin
         failures++; $display("FAIL abort_prior_data got=%h exp=cafef00d", rd2);
      end
`ifdef MEM_STATS_EN
      checks++; if (wrc2 !== 16'h0 || rdc2 !== 16'h1) begin
         failures++; $display("FAIL abort_stats got=%h/%h exp=1/0", rdc2, wrc2);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero_wait();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      repeat (2) @(negedge clk);
      checks++; if (q2.size() != 0 || q0.size() != 0) begin
         failures++; $display("FAIL missing_responses got=%0d/%0d exp=0/0", q2.size(), q0.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
